two_digit_bcd_counter: RTL and testbench

//   Two-digit decimal (BCD) up-counter that runs 00..MAX_COUNT and wraps to 00.

---
 rtl/two_digit_bcd_counter.sv | 76 +++++++
 tb/tb_two_digit_bcd_counter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/two_digit_bcd_counter.sv
// Two-digit BCD up-counter (00..MAX_COUNT, wraps to 00) with optional prescaler,
// driving two active-low 7-segment displays (HEX1 = tens, HEX0 = ones).
module two_digit_bcd_counter #(
    parameter int MAX_COUNT = 20,
    parameter int TICK_DIV  = 1
) (
    input  logic       CLOCK_50,
    input  logic       KEY0,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1
);

    localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [3:0]      MAX_TENS = 4'(MAX_COUNT / 10);
    localparam logic [3:0]      MAX_ONES = 4'(MAX_COUNT % 10);

    logic [3:0]       ones;
    logic [3:0]       tens;
    logic [CNT_W-1:0] cnt;
    logic             tick;

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge CLOCK_50 or posedge KEY0) begin
        if (KEY0) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Terminal count is compared digit-wise in decimal, not as a binary value.
    always_ff @(posedge CLOCK_50 or posedge KEY0) begin
        if (KEY0) begin
            ones <= '0;
            tens <= '0;
        end else if (tick) begin
            if (tens == MAX_TENS && ones == MAX_ONES) begin
                ones <= '0;
                tens <= '0;
            end else if (ones == 4'd9) begin
                ones <= '0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        HEX0 = seg7(ones);
        HEX1 = seg7(tens);
    end

endmodule

// File: tb/tb_two_digit_bcd_counter.sv
// Bench for two_digit_bcd_counter: default instance plus a TICK_DIV=4 instance,
// checked every cycle against an arithmetic model and at directed points with literals.
module tb_two_digit_bcd_counter;

    localparam int MAXC = 20;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;

    logic [6:0] seg_tab [10];

    logic       clk;
    logic       rst;
    logic [6:0] hex0_a, hex1_a, hex0_b, hex1_b;

    int checks = 0;
    int errors = 0;

    // Model: plain decimal values, prescaler as an edge counter modulo the divider.
    int m_a = 0;
    int m_b = 0;
    int p_b = 0;

    two_digit_bcd_counter #(.MAX_COUNT(MAXC), .TICK_DIV(1)) dut_a (
        .CLOCK_50 (clk),
        .KEY0     (rst),
        .HEX0     (hex0_a),
        .HEX1     (hex1_a)
    );

    two_digit_bcd_counter #(.MAX_COUNT(MAXC), .TICK_DIV(4)) dut_b (
        .CLOCK_50 (clk),
        .KEY0     (rst),
        .HEX0     (hex0_b),
        .HEX1     (hex1_b)
    );

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
    end

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a <= 0;
            m_b <= 0;
            p_b <= 0;
        end else begin
            m_a <= (m_a == MAXC) ? 0 : m_a + 1;
            if (p_b == 3) begin
                p_b <= 0;
                m_b <= (m_b == MAXC) ? 0 : m_b + 1;
            end else begin
                p_b <= p_b + 1;
            end
        end
    end

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("model_a_hex0", hex0_a, seg_tab[m_a % 10]);
        check("model_a_hex1", hex1_a, seg_tab[m_a / 10]);
        check("model_b_hex0", hex0_b, seg_tab[m_b % 10]);
        check("model_b_hex1", hex1_b, seg_tab[m_b / 10]);
    end

    task automatic expect_disp(input string name, input logic [6:0] act1, input logic [6:0] act0,
                               input logic [6:0] exp1, input logic [6:0] exp0);
        check({name, "_hex1"}, act1, exp1);
        check({name, "_hex0"}, act0, exp0);
    endtask

    initial begin
        rst = 1'b1;
        #50;
        @(negedge clk);
        expect_disp("reset_a", hex1_a, hex0_a, S0, S0);
        expect_disp("reset_b", hex1_b, hex0_b, S0, S0);
        rst = 1'b0;

        repeat (3) @(posedge clk);
        #1 expect_disp("div4_3edges", hex1_b, hex0_b, S0, S0);
        @(posedge clk);
        #1 expect_disp("div4_4edges", hex1_b, hex0_b, S0, S1);
        expect_disp("cnt_04", hex1_a, hex0_a, S0, S4);

        repeat (5) @(posedge clk);
        #1 expect_disp("cnt_09", hex1_a, hex0_a, S0, S9);
        @(posedge clk);
        #1 expect_disp("carry_10", hex1_a, hex0_a, S1, S0);
        expect_disp("div4_10edges", hex1_b, hex0_b, S0, S2);

        repeat (10) @(posedge clk);
        #1 expect_disp("cnt_20", hex1_a, hex0_a, S2, S0);
        @(posedge clk);
        #1 expect_disp("wrap_00", hex1_a, hex0_a, S0, S0);
        @(posedge clk);
        #1 expect_disp("wrap_01", hex1_a, hex0_a, S0, S1);

        repeat (6) @(posedge clk);
        #1 expect_disp("cnt_07", hex1_a, hex0_a, S0, S7);
        @(negedge clk);
        #3 rst = 1'b1;
        #1 expect_disp("async_rst", hex1_a, hex0_a, S0, S0);
        #40 expect_disp("rst_hold", hex1_a, hex0_a, S0, S0);
        @(negedge clk);
        rst = 1'b0;

        repeat (15) @(posedge clk);
        #1 expect_disp("resume_15", hex1_a, hex0_a, S1, S5);

        repeat (50) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
